// File: rtl/mux_n_to_1_reg.sv
// N-to-1 registered channel mux with valid/ready handshake.
// The channel is chosen by explicit select (RR=0) or by a round-robin arbiter over req (RR=1).

module mux_n_to_1_reg_lane #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] chan,
  input  logic             hit,
  output logic [WIDTH-1:0] gated
);
  assign gated = hit ? chan : '0;
endmodule

module mux_n_to_1_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int RR    = 0,
  localparam int SELW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 sel_err
);
  logic [N-1:0][WIDTH-1:0] chans;
  logic [N-1:0][WIDTH-1:0] gated;
  logic [N-1:0]            hit;
  logic [WIDTH-1:0]        mux_data;
  logic [SELW-1:0]         ptr, grant, ptr_nxt;
  logic [SELW:0]           scan;
  logic [SELW-1:0]         scan_idx;
  logic                    found, sel_oor, cap;

  assign chans    = data_in;
  assign in_ready = !out_valid || out_ready;
  assign sel_oor  = {1'b0, sel} >= (SELW+1)'(N);
  assign cap      = in_valid && in_ready && ((RR == 0) || (|req));

  // Walk ptr, ptr+1, ... with modulo-N wrap; first set request wins.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    scan     = '0;
    scan_idx = '0;
    for (int i = 0; i < N; i++) begin
      scan = {1'b0, ptr} + (SELW+1)'(i);
      if (scan >= (SELW+1)'(N)) scan = scan - (SELW+1)'(N);
      scan_idx = scan[SELW-1:0];
      if (!found && req[scan_idx]) begin
        grant = scan_idx;
        found = 1'b1;
      end
    end
  end

  assign ptr_nxt = (grant == SELW'(N-1)) ? '0 : grant + 1'b1;

  // One-hot AND-OR select; an out-of-range sel hits no lane and yields zero.
  for (genvar k = 0; k < N; k++) begin : g_lane
    assign hit[k] = (RR != 0) ? (found && (grant == SELW'(k))) : (sel == SELW'(k));
    mux_n_to_1_reg_lane #(.WIDTH(WIDTH)) u_lane (
      .chan  (chans[k]),
      .hit   (hit[k]),
      .gated (gated[k])
    );
  end

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < N; k++) mux_data = mux_data | gated[k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      sel_err   <= 1'b0;
      ptr       <= '0;
    end else if (cap) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_sel   <= (RR != 0) ? grant : sel;
      if (RR != 0) ptr <= ptr_nxt;
      if (RR == 0 && sel_oor) sel_err <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// Directed bench: explicit-select N=4 and N=3 instances plus a round-robin N=4 instance.

module tb_mux_n_to_1_reg;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // explicit select, N=4
  logic        iv0, or0, ir0, ov0, se0;
  logic [1:0]  sel0, osel0;
  logic [3:0]  req0;
  logic [127:0] din0;
  logic [31:0] od0;
  // explicit select, N=3
  logic        iv3, or3, ir3, ov3, se3;
  logic [1:0]  sel3, osel3;
  logic [2:0]  req3;
  logic [95:0] din3;
  logic [31:0] od3;
  // round robin, N=4
  logic        ivr, orr, irr, ovr, ser;
  logic [1:0]  selr, oselr;
  logic [3:0]  reqr;
  logic [127:0] dinr;
  logic [31:0] odr;

  mux_n_to_1_reg #(.WIDTH(32), .N(4), .RR(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .sel(sel0), .req(req0),
    .data_in(din0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_sel(osel0),
    .sel_err(se0));
  mux_n_to_1_reg #(.WIDTH(32), .N(3), .RR(0)) dut3 (
    .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(ir3), .sel(sel3), .req(req3),
    .data_in(din3), .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_sel(osel3),
    .sel_err(se3));
  mux_n_to_1_reg #(.WIDTH(32), .N(4), .RR(1)) dutr (
    .clk(clk), .reset(reset), .in_valid(ivr), .in_ready(irr), .sel(selr), .req(reqr),
    .data_in(dinr), .out_valid(ovr), .out_ready(orr), .out_data(odr), .out_sel(oselr),
    .sel_err(ser));

  function automatic logic [31:0] chv(input int k);
    return 32'h11111111 * (k + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if (ov0 !== 1'b0 || od0 !== 32'h0 || osel0 !== 2'd0 || se0 !== 1'b0 || ir0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h sel=%0d err=%b ready=%b, need 0 0 0 0 1",
               ov0, od0, osel0, se0, ir0);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    sel0 = 2'd2; iv0 = 1'b1; or0 = 1'b1;
    tick();
    iv0 = 1'b0;
    checks++;
    if (ov0 !== 1'b1 || od0 !== 32'h33333333 || osel0 !== 2'd2) begin
      errors++;
      $display("FAIL basic_capture: valid=%b data=%h sel=%0d, need 1 33333333 2", ov0, od0, osel0);
    end
    tick();
    checks++;
    if (ov0 !== 1'b0 || od0 !== 32'h33333333 || osel0 !== 2'd2) begin
      errors++;
      $display("FAIL basic_consume: valid=%b data=%h sel=%0d, need 0 33333333 2", ov0, od0, osel0);
    end
  endtask

  task automatic test_stall();
    or0 = 1'b0; sel0 = 2'd1; iv0 = 1'b1;
    tick();
    sel0 = 2'd3;
    #1;
    checks++;
    if (ov0 !== 1'b1 || od0 !== 32'h22222222 || ir0 !== 1'b0) begin
      errors++;
      $display("FAIL stall_first: valid=%b data=%h ready=%b, need 1 22222222 0", ov0, od0, ir0);
    end
    din0[1*32 +: 32] = 32'hDEADBEEF;
    tick();
    checks++;
    if (ov0 !== 1'b1 || od0 !== 32'h22222222 || osel0 !== 2'd1 || ir0 !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: valid=%b data=%h sel=%0d ready=%b, need 1 22222222 1 0",
               ov0, od0, osel0, ir0);
    end
    din0[1*32 +: 32] = chv(1);
    or0 = 1'b1;
    #1;
    checks++;
    if (ir0 !== 1'b1) begin
      errors++;
      $display("FAIL stall_ready_comb: ready=%b, need 1", ir0);
    end
    tick();
    iv0 = 1'b0;
    checks++;
    if (ov0 !== 1'b1 || od0 !== 32'h44444444 || osel0 !== 2'd3) begin
      errors++;
      $display("FAIL stall_release: valid=%b data=%h sel=%0d, need 1 44444444 3", ov0, od0, osel0);
    end
    tick();
    checks++;
    if (ov0 !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: valid=%b, need 0", ov0);
    end
  endtask

  task automatic test_data_change();
    or0 = 1'b0; sel0 = 2'd0; iv0 = 1'b1;
    tick();
    iv0 = 1'b0;
    din0[31:0] = 32'hCAFEF00D;
    tick();
    checks++;
    if (od0 !== 32'h11111111 || osel0 !== 2'd0) begin
      errors++;
      $display("FAIL data_after_capture: data=%h sel=%0d, need 11111111 0", od0, osel0);
    end
    din0[31:0] = chv(0);
    or0 = 1'b1;
    tick();
    tick();
    checks++;
    if (ov0 !== 1'b0 || od0 !== 32'h11111111) begin
      errors++;
      $display("FAIL idle_ready: valid=%b data=%h, need 0 11111111", ov0, od0);
    end
  endtask

  task automatic test_sel_err();
    sel3 = 2'd3; iv3 = 1'b1; or3 = 1'b1;
    tick();
    checks++;
    if (ov3 !== 1'b1 || od3 !== 32'h0 || osel3 !== 2'd3 || se3 !== 1'b1) begin
      errors++;
      $display("FAIL sel_oor: valid=%b data=%h sel=%0d err=%b, need 1 0 3 1", ov3, od3, osel3, se3);
    end
    sel3 = 2'd1;
    tick();
    iv3 = 1'b0;
    checks++;
    if (od3 !== 32'hA0000001 || osel3 !== 2'd1 || se3 !== 1'b1) begin
      errors++;
      $display("FAIL sel_err_sticky: data=%h sel=%0d err=%b, need a0000001 1 1", od3, osel3, se3);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (se3 !== 1'b0 || ov3 !== 1'b0) begin
      errors++;
      $display("FAIL sel_err_reset: err=%b valid=%b, need 0 0", se3, ov3);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int exp_a[4] = '{1, 3, 1, 3};
    int exp_b[5] = '{0, 1, 2, 3, 0};
    reqr = 4'b1010; ivr = 1'b1; orr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ovr !== 1'b1 || oselr !== 2'(exp_a[i]) || odr !== chv(exp_a[i]) || ser !== 1'b0) begin
        errors++;
        $display("FAIL rr_1010[%0d]: valid=%b grant=%0d data=%h err=%b, need 1 %0d %h 0",
                 i, ovr, oselr, odr, ser, exp_a[i], chv(exp_a[i]));
      end
    end
    ivr = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reqr = 4'b1111; ivr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ovr !== 1'b1 || oselr !== 2'(exp_b[i]) || odr !== chv(exp_b[i])) begin
        errors++;
        $display("FAIL rr_1111[%0d]: valid=%b grant=%0d data=%h, need 1 %0d %h",
                 i, ovr, oselr, odr, exp_b[i], chv(exp_b[i]));
      end
    end
    reqr = 4'b0000;
    tick();
    checks++;
    if (ovr !== 1'b0 || oselr !== 2'd0 || irr !== 1'b1) begin
      errors++;
      $display("FAIL rr_noreq: valid=%b sel=%0d ready=%b, need 0 0 1", ovr, oselr, irr);
    end
    reqr = 4'b1111;
    tick();
    ivr = 1'b0;
    checks++;
    if (ovr !== 1'b1 || oselr !== 2'd1) begin
      errors++;
      $display("FAIL rr_ptr_kept: valid=%b grant=%0d, need 1 1", ovr, oselr);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int delivered = 0;
    iv0 = 1'b1; or0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel0 = 2'((i * 3) % 4);
      tick();
      checks++;
      if (ov0 !== 1'b1 || od0 !== chv((i * 3) % 4) || osel0 !== 2'((i * 3) % 4)) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%b data=%h sel=%0d, need 1 %h %0d",
                 i, ov0, od0, osel0, chv((i * 3) % 4), (i * 3) % 4);
      end else begin
        delivered++;
      end
    end
    iv0 = 1'b0;
    tick();
    checks++;
    if (delivered !== 8 || ov0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: words=%0d valid=%b, need 8 0", delivered, ov0);
    end
  endtask

  task automatic test_reset_mid();
    or0 = 1'b0; sel0 = 2'd3; iv0 = 1'b1;
    tick();
    checks++;
    if (ov0 !== 1'b1 || od0 !== 32'h44444444) begin
      errors++;
      $display("FAIL pre_reset_hold: valid=%b data=%h, need 1 44444444", ov0, od0);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (ov0 !== 1'b0 || od0 !== 32'h0 || osel0 !== 2'd0 || ovr !== 1'b0 || oselr !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h sel=%0d rr_valid=%b rr_sel=%0d, need 0 0 0 0 0",
               ov0, od0, osel0, ovr, oselr);
    end
    or0 = 1'b1; ivr = 1'b1; reqr = 4'b1111; orr = 1'b1;
    tick();
    checks++;
    if (ov0 !== 1'b0 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL no_capture_in_reset: valid=%b rr_valid=%b, need 0 0", ov0, ovr);
    end
    reset = 1'b0;
    tick();
    iv0 = 1'b0; ivr = 1'b0;
    checks++;
    if (ov0 !== 1'b1 || od0 !== 32'h44444444 || ovr !== 1'b1 || oselr !== 2'd0 || odr !== chv(0)) begin
      errors++;
      $display("FAIL post_reset: valid=%b data=%h rr_valid=%b rr_grant=%0d rr_data=%h, need 1 44444444 1 0 11111111",
               ov0, od0, ovr, oselr, odr);
    end
    tick();
  endtask

  initial begin
    iv0 = 0; or0 = 0; sel0 = 0; req0 = '0;
    iv3 = 0; or3 = 0; sel3 = 0; req3 = '0;
    ivr = 0; orr = 0; selr = 0; reqr = '0;
    for (int k = 0; k < 4; k++) begin
      din0[k*32 +: 32] = chv(k);
      dinr[k*32 +: 32] = chv(k);
    end
    for (int k = 0; k < 3; k++) din3[k*32 +: 32] = 32'hA0000000 + 32'(k);
    test_reset();
    test_basic();
    test_stall();
    test_data_change();
    test_sel_err();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_n_to_1_reg.md
MUX_N_TO_1_REG -- requirements
Module: mux_n_to_1_reg

Interface
REQ-001 Parameter WIDTH, default 32: data width of each channel; SHALL support 1..64.
REQ-002 Parameter N, default 4: channel count; SHALL support 2..16.
REQ-003 Parameter RR, default 0: 0 = explicit select mode, 1 = round-robin mode; SELW SHALL be a derived localparam equal to max(1, clog2(N)).
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  capture request from the upstream controller.
REQ-007 in_ready  out  1  the block can accept a capture this cycle.
REQ-008 sel  in  SELW  channel index; used only when RR=0.
REQ-009 req  in  N  per-channel request vector; used only when RR=1.
REQ-010 data_in  in  N*WIDTH  flattened channels; channel k SHALL occupy bits [k*WIDTH +: WIDTH].
REQ-011 out_valid  out  1  out_data holds a captured word.
REQ-012 out_ready  in  1  the downstream stage consumes the word this cycle.
REQ-013 out_data  out  WIDTH  registered selected word.
REQ-014 out_sel  out  SELW  index of the channel captured into out_data.
REQ-015 sel_err  out  1  sticky out-of-range select flag.

Function
REQ-016 in_ready SHALL equal (!out_valid || out_ready) and be purely combinational; it SHALL NOT depend on in_valid.
REQ-017 A capture SHALL occur on a rising edge when in_valid && in_ready, and, when RR=1, also (|req).
REQ-018 Latency SHALL be one cycle: captured data is visible on out_data, with out_valid=1, in the cycle after the capture edge.
REQ-019 RR=0: a capture SHALL load channel sel into out_data and sel into out_sel.
REQ-020 RR=0, sel >= N: a capture SHALL load out_data=0, out_sel=sel and out_valid=1, and SHALL set sel_err=1.
REQ-021 sel_err SHALL remain 1 until reset; it SHALL be constant 0 when RR=1.
REQ-022 RR=1: the block SHALL keep an internal pointer ptr (SELW bits). Grant SHALL be the first index g with req[g]=1, scanning ptr, ptr+1, ... with modulo-N wrap.
REQ-023 RR=1: on capture, out_data SHALL load channel g, out_sel SHALL load g, and ptr SHALL become (g+1) mod N; wrap from N-1 SHALL give 0.
REQ-024 RR=1 with req=0: in_valid SHALL be ignored, with no capture and no ptr change; in_ready SHALL still follow REQ-016.
REQ-025 Hold: while out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL be stable regardless of in_valid, sel, req or data_in.
REQ-026 Consume only: when out_valid=1, out_ready=1 and there is no capture, out_valid SHALL go to 0 on the next edge; out_data and out_sel SHALL hold their last values.
REQ-027 Simultaneous consume and capture: when out_valid=1, out_ready=1 and a capture occurs, the new word SHALL replace the old and out_valid SHALL stay 1, giving one word per cycle sustained.
REQ-028 out_ready with out_valid=0 SHALL have no effect.
REQ-029 Changes on data_in after the capture edge SHALL NOT affect out_data.

Reset
REQ-030 reset=1 SHALL immediately, without waiting for a clock edge, force out_valid=0, out_data=0, out_sel=0, sel_err=0 and ptr=0.
REQ-031 A held, unconsumed word SHALL be discarded by reset; no capture SHALL occur on an edge while reset=1.
REQ-032 After reset is released, the first capture SHALL occur no earlier than the first rising edge with reset=0.

Verification
REQ-033 RR=0, N=4, WIDTH=32, channels = 0x11111111*(k+1), sel=2, in_valid pulse, out_ready=1 -> next cycle out_valid=1, out_data=0x33333333, out_sel=2; one cycle later out_valid=0.
REQ-034 RR=0, out_ready=0, captures with sel=1 then sel=3 -> out_data stays 0x22222222 while stalled and in_ready=0; after out_ready=1 for one cycle, 0x44444444 appears on the following cycle.
REQ-035 RR=0, N=3, sel=3, in_valid=1 -> out_data=0, out_valid=1, sel_err=1; sel_err stays 1 after later valid captures until reset.
REQ-036 RR=1, N=4, req=4'b1010, out_ready=1, in_valid held high -> grants 1,3,1,3 on successive cycles; with req=4'b1111 after reset -> grants 0,1,2,3,0 (wrap).
REQ-037 Continuous in_valid=1 and out_ready=1 for 8 cycles -> 8 words delivered back-to-back, with out_valid high throughout after the first cycle.
REQ-038 Assert reset mid-clock while out_valid=1 and out_ready=0 -> out_valid=0 and out_data=0 before the next edge; ptr restarts at 0.
